reg_file: RTL and testbench
===========================

# reg_file

Architectural register file and status-flag register for the single-cycle RISC datapath. It sits directly upstream of the ALU: its two read ports drive the ALU's `operand1`/`operand2` inputs. It also captures the ALU's `{carry, overflow, negative, zero}` outputs and the writeback result at the clock edge that ends each instruction. Eight general registers are provided, with R0 hard-wired to zero.

## Interface
- `width`, 16, data width of each register and of the operand/writeback buses (same value as the ALU's `width`).
- `addr_width`, 3, register address width; register count is 2**addr_width.

- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  reset; one clock, reset is asynchronous and active-low.
- `rs1_addr`  in  addr_width  read-port-1 register select.
- `rs2_addr`  in  addr_width  read-port-2 register select.
- `operand1`  out  width  contents of `rs1_addr` (to ALU `operand1`).
- `operand2`  out  width  contents of `rs2_addr` (to ALU `operand2`).
- `wr_en`  in  1  writeback enable.
- `rd_addr`  in  addr_width  writeback destination.
- `wr_data`  in  width  writeback value (ALU `result` or load data, muxed outside).
- `flag_we`  in  1  capture ALU flags this cycle.
- `carry_in`, `overflow_in`, `negative_in`, `zero_in`  in  1 each  ALU flag outputs.
- `flags`  out  4  registered status `{C,V,N,Z}`, bit 3 = C, bit 0 = Z.
- `wr_count`  out  16  number of committed non-R0 register writes since reset; wraps 0xFFFF -> 0x0000.

## Operation
- Storage: registers R1..R(2**addr_width-1), each `width` bits. R0 is not stored. Reads of R0 return 0.
- Read ports are combinational from the stored array, with write-through bypass:
  - If `wr_en`=1, `rd_addr`==`rsN_addr` and `rsN_addr`!=0, then `operandN` = `wr_data` in the same cycle.
  - Otherwise `operandN` = stored value.
  - Both ports bypass independently, so `rs1_addr`==`rs2_addr`==`rd_addr` drives `wr_data` on both.
- Write: on a rising edge with `wr_en`=1 and `rd_addr`!=0, the register at `rd_addr` takes `wr_data`, and `wr_count` increments by 1 (modulo 2**16).
- Writes to R0 are discarded and do not increment `wr_count`.
- `wr_en`=0: the array and `wr_count` hold.
- Flags: on a rising edge with `flag_we`=1, `flags` <= `{carry_in, overflow_in, negative_in, zero_in}`. With `flag_we`=0, `flags` holds.
- Flags are independent of `wr_en`: a compare updates flags without a register write, and a load writes a register without touching flags.
- The inputs are not checked for X. Operand and flag values are passed through unmodified, with no width extension or truncation.

## Timing
- Reset (`rst_n`=0, asynchronous, no clock needed):
  - all registers, `flags` and `wr_count` go to 0 immediately;
  - `operand1`/`operand2` therefore read 0, except that the combinational bypass still forwards `wr_data` when `wr_en`=1.
- While `rst_n`=0, rising edges perform no writes and no flag capture.
- Deassertion is synchronised externally; the first edge with `rst_n`=1 may write.
- Reset asserted mid-cycle clears state at once. A write pending at that cycle's edge is lost.
- Read latency: 0 cycles, combinational.
- Write-to-read: a value written at edge k appears from storage after edge k. Via the bypass it is already visible before edge k in the writing cycle.
- Flag latency: ALU flags presented in cycle k appear on `flags` after edge k, for use by a branch in cycle k+1.
- Simultaneous `wr_en` and `flag_we` in one cycle: both commit at the same edge.

## Test plan
- Reset: assert `rst_n`=0 with no clock running -> `operand1`=`operand2`=0x0000, `flags`=4'b0000, `wr_count`=0 asynchronously. Deassert and read R1..R7 -> all 0x0000.
- Write/read: write R1=0x0029, then R2=0x0012 (`wr_en`=1, two edges). Set `rs1_addr`=1, `rs2_addr`=2 -> `operand1`=0x0029, `operand2`=0x0012, `wr_count`=2.
- Bypass and R0:
  - with R3=0x1111 stored, set `wr_en`=1, `rd_addr`=3, `wr_data`=0x9819, `rs1_addr`=`rs2_addr`=3 -> both operands read 0x9819 before the edge;
  - write 0xFFFF to R0 -> reading R0 gives 0x0000 and `wr_count` is unchanged.
- Flags:
  - `flag_we`=1 with C=1, V=0, N=1, Z=0 -> `flags`=4'b1010 after the edge;
  - next cycle `flag_we`=0 with inputs 4'b0101 -> `flags` stays 4'b1010;
  - a concurrent `wr_en` write of R4=0x0010 also commits at that edge.
- Mid-operation reset: load R5=0xABCD and `flags`=4'b1111. Pulse `rst_n` low between edges while `wr_en`=1, `rd_addr`=6 -> R5 and R6 read 0, `flags`=0, `wr_count`=0, and no write occurs at the edge during reset.
- Counter wrap: perform 65536 writes to R7 -> `wr_count` returns to 0x0000, and R7 holds the last value written.

Source files
------------

// File: rtl/reg_file.sv
// ============================================================================
// reg_file : eight-entry register file (R0 = 0) with write-through bypass,
//            {C,V,N,Z} status flags and a committed-write counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module reg_file #(
   parameter int WIDTH      = 16,
   parameter int ADDR_WIDTH = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_WIDTH-1:0] rs1_addr,
   input  logic [ADDR_WIDTH-1:0] rs2_addr,
   output logic [WIDTH-1:0]      operand1,
   output logic [WIDTH-1:0]      operand2,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic [WIDTH-1:0]      wr_data,
   input  logic                  flag_we,
   input  logic                  carry_in,
   input  logic                  overflow_in,
   input  logic                  negative_in,
   input  logic                  zero_in,
   output logic [3:0]            flags,
   output logic [15:0]           wr_count
);

   localparam int NUM_REGS = 2 ** ADDR_WIDTH;

   logic [WIDTH-1:0] store [1:NUM_REGS-1];
   logic [WIDTH-1:0] rd1_stored;
   logic [WIDTH-1:0] rd2_stored;
   logic             commit;

   // R0 is never stored, so a write addressed to it commits nothing
   assign commit = wr_en && (rd_addr != '0);

   genvar gi;
   generate
      for (gi = 1; gi < NUM_REGS; gi++) begin : g_reg
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               store[gi] <= '0;
            end else if (commit && (rd_addr == ADDR_WIDTH'(gi))) begin
               store[gi] <= wr_data;
            end
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_count <= '0;
         flags    <= '0;
      end else begin
         if (commit) begin
            wr_count <= wr_count + 16'd1;
         end
         if (flag_we) begin
            flags <= {carry_in, overflow_in, negative_in, zero_in};
         end
      end
   end

   always_comb begin
      rd1_stored = '0;
      rd2_stored = '0;
      for (int i = 1; i < NUM_REGS; i++) begin
         if (rs1_addr == ADDR_WIDTH'(i)) rd1_stored = store[i];
         if (rs2_addr == ADDR_WIDTH'(i)) rd2_stored = store[i];
      end
   end

   // Same-cycle forwarding of the writeback value; never applies to R0
   assign operand1 = (commit && (rd_addr == rs1_addr)) ? wr_data : rd1_stored;
   assign operand2 = (commit && (rd_addr == rs2_addr)) ? wr_data : rd2_stored;

endmodule

`default_nettype wire

// File: tb/tb_reg_file.sv
// ============================================================================
// tb_reg_file : directed self-checking bench for reg_file.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_reg_file;

   logic        clk = 1'b0;
   logic        clk_en = 1'b0;
   logic        rst_n;
   logic [2:0]  rs1_addr, rs2_addr, rd_addr;
   logic [15:0] operand1, operand2, wr_data;
   logic        wr_en, flag_we;
   logic        carry_in, overflow_in, negative_in, zero_in;
   logic [3:0]  flags;
   logic [15:0] wr_count;

   int total  = 0;
   int passed = 0;

   reg_file #(.WIDTH(16), .ADDR_WIDTH(3)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .rs1_addr    (rs1_addr),
      .rs2_addr    (rs2_addr),
      .operand1    (operand1),
      .operand2    (operand2),
      .wr_en       (wr_en),
      .rd_addr     (rd_addr),
      .wr_data     (wr_data),
      .flag_we     (flag_we),
      .carry_in    (carry_in),
      .overflow_in (overflow_in),
      .negative_in (negative_in),
      .zero_in     (zero_in),
      .flags       (flags),
      .wr_count    (wr_count)
   );

   always begin
      #5;
      if (clk_en) clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b1;
      rs1_addr = 3'd1; rs2_addr = 3'd2; rd_addr = 3'd0;
      wr_en = 1'b0; wr_data = 16'h0000; flag_we = 1'b0;
      {carry_in, overflow_in, negative_in, zero_in} = 4'b0000;

      // asynchronous reset with the clock stopped
      #2 rst_n = 1'b0;
      #1;
      check("reset_op1",   operand1, 16'h0000);
      check("reset_op2",   operand2, 16'h0000);
      check("reset_flags", flags,    4'b0000);
      check("reset_count", wr_count, 16'h0000);
      #3 rst_n = 1'b1;
      clk_en = 1'b1;
      for (int i = 1; i < 8; i++) begin
         rs1_addr = 3'(i);
         #1;
         check($sformatf("reset_r%0d", i), operand1, 16'h0000);
      end

      // basic write and read
      tick();
      wr_en = 1'b1; rd_addr = 3'd1; wr_data = 16'h0029;
      tick();
      rd_addr = 3'd2; wr_data = 16'h0012;
      tick();
      wr_en = 1'b0; rs1_addr = 3'd1; rs2_addr = 3'd2;
      #1;
      check("read_r1",  operand1, 16'h0029);
      check("read_r2",  operand2, 16'h0012);
      check("count_2",  wr_count, 16'd2);

      // bypass
      wr_en = 1'b1; rd_addr = 3'd3; wr_data = 16'h1111;
      tick();
      wr_en = 1'b0; rs1_addr = 3'd3; rs2_addr = 3'd3;
      #1;
      check("stored_r3", operand1, 16'h1111);
      wr_en = 1'b1; wr_data = 16'h9819;
      #1;
      check("bypass_op1", operand1, 16'h9819);
      check("bypass_op2", operand2, 16'h9819);
      tick();
      wr_en = 1'b0;
      #1;
      check("after_bypass_r3", operand1, 16'h9819);
      check("count_4", wr_count, 16'd4);

      // R0 writes are discarded
      wr_en = 1'b1; rd_addr = 3'd0; wr_data = 16'hFFFF; rs1_addr = 3'd0; rs2_addr = 3'd0;
      #1;
      check("r0_no_bypass", operand1, 16'h0000);
      tick();
      wr_en = 1'b0;
      #1;
      check("r0_read",  operand2, 16'h0000);
      check("r0_count", wr_count, 16'd4);

      // flags with concurrent write
      flag_we = 1'b1; {carry_in, overflow_in, negative_in, zero_in} = 4'b1010;
      wr_en = 1'b1; rd_addr = 3'd4; wr_data = 16'h0010;
      tick();
      flag_we = 1'b0; {carry_in, overflow_in, negative_in, zero_in} = 4'b0101;
      wr_en = 1'b0; rs1_addr = 3'd4;
      #1;
      check("flags_1010", flags,    4'b1010);
      check("flag_wr_r4", operand1, 16'h0010);
      check("count_5",    wr_count, 16'd5);
      tick();
      check("flags_hold", flags, 4'b1010);

      // mid-operation reset
      flag_we = 1'b1; {carry_in, overflow_in, negative_in, zero_in} = 4'b1111;
      wr_en = 1'b1; rd_addr = 3'd5; wr_data = 16'hABCD;
      tick();
      flag_we = 1'b0;
      rd_addr = 3'd6; wr_data = 16'h1234; rs1_addr = 3'd5; rs2_addr = 3'd6;
      #1;
      check("pre_rst_r5",    operand1, 16'hABCD);
      check("pre_rst_flags", flags,    4'b1111);
      #1 rst_n = 1'b0;
      #1;
      check("mid_rst_r5",     operand1, 16'h0000);
      check("mid_rst_bypass", operand2, 16'h1234);
      check("mid_rst_flags",  flags,    4'b0000);
      check("mid_rst_count",  wr_count, 16'h0000);
      tick();
      rst_n = 1'b1; wr_en = 1'b0;
      #1;
      check("post_rst_r5",    operand1, 16'h0000);
      check("post_rst_r6",    operand2, 16'h0000);
      check("post_rst_count", wr_count, 16'h0000);

      // counter wrap with 65536 writes to R7
      wr_en = 1'b1; rd_addr = 3'd7; rs1_addr = 3'd7;
      for (int i = 0; i < 65536; i++) begin
         wr_data = 16'(i) ^ 16'h5A5A;
         tick();
         if (i == 0) check("count_first", wr_count, 16'd1);
      end
      wr_en = 1'b0;
      #1;
      check("wrap_count", wr_count, 16'h0000);
      check("wrap_r7",    operand1, 16'hA5A5);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

`default_nettype wire
